// File: rtl/rv_immgen_pipe.sv
// Pipelined RISC-V immediate generator: decodes instr[31:7] by format into an XLEN-bit
// immediate, then carries it through STAGES elastic registers with valid/ready and flush.
module rv_immgen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_immgen_valid,
  output logic             o_immgen_ready,
  input  logic [24:0]      i_immgen_instr,
  input  logic [2:0]       i_immgen_ctrl,
  input  logic [TAG_W-1:0] i_immgen_tag,
  output logic             o_immgen_valid,
  input  logic             i_immgen_ready,
  output logic [XLEN-1:0]  o_immgen_res,
  output logic [TAG_W-1:0] o_immgen_tag,
  output logic             o_immgen_err
);

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_J     = 3'd3,
    FMT_U     = 3'd4,
    FMT_SHAMT = 3'd5,
    FMT_ZIMM  = 3'd6,
    FMT_RSVD  = 3'd7
  } fmt_e;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("rv_immgen_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("rv_immgen_pipe: STAGES must be in 1..3");
  end

  // f holds instr[31:7], so instruction bit b sits at f[b-7].
  function automatic logic signed [XLEN-1:0] imm_decode(input logic [24:0] f, input fmt_e fmt);
    logic signed [XLEN-1:0] r;
    r = '0;
    case (fmt)
      FMT_I:     r = {{(XLEN-12){f[24]}}, f[24:13]};
      FMT_S:     r = {{(XLEN-12){f[24]}}, f[24:18], f[4:0]};
      FMT_B:     r = {{(XLEN-13){f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
      FMT_J:     r = {{(XLEN-21){f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
      FMT_U:     r = {{(XLEN-32){f[24]}}, f[24:5], 12'b0};
      FMT_SHAMT: r = (XLEN == 64) ? XLEN'(f[18:13]) : XLEN'(f[17:13]);
      FMT_ZIMM:  r = XLEN'(f[12:8]);
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic fmt_illegal(input fmt_e fmt);
    return fmt == FMT_RSVD;
  endfunction

  logic                   vld_p [STAGES];
  logic signed [XLEN-1:0] res_p [STAGES];
  logic [TAG_W-1:0]       tag_p [STAGES];
  logic                   err_p [STAGES];

  logic                   src_vld [STAGES];
  logic signed [XLEN-1:0] src_res [STAGES];
  logic [TAG_W-1:0]       src_tag [STAGES];
  logic                   src_err [STAGES];
  logic                   load    [STAGES];

  // Each stage is fed by the decoder (stage 0) or by the stage before it.
  always_comb begin
    src_vld[0] = i_immgen_valid;
    src_res[0] = imm_decode(i_immgen_instr, fmt_e'(i_immgen_ctrl));
    src_tag[0] = i_immgen_tag;
    src_err[0] = fmt_illegal(fmt_e'(i_immgen_ctrl));
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_p[k-1];
      src_res[k] = res_p[k-1];
      src_tag[k] = tag_p[k-1];
      src_err[k] = err_p[k-1];
    end
  end

  // A stage loads when empty or when everything downstream of it moves; a bubble
  // anywhere below therefore lets the stages above it advance.
  always_comb begin
    logic chain;
    chain = i_immgen_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain   = !vld_p[k] || chain;
      load[k] = chain;
    end
  end

  // ---- stage registers: data only updates on a valid load so stalls and bubbles hold it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        res_p[k] <= '0;
        tag_p[k] <= '0;
        err_p[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_p[k] <= src_vld[k] && !i_flush;
          if (src_vld[k]) begin
            res_p[k] <= src_res[k];
            tag_p[k] <= src_tag[k];
            err_p[k] <= src_err[k];
          end
        end else if (i_flush) begin
          vld_p[k] <= 1'b0;
        end
      end
    end
  end

  // ---- output stage
  assign o_immgen_ready = load[0];
  assign o_immgen_valid = vld_p[STAGES-1];
  assign o_immgen_res   = res_p[STAGES-1];
  assign o_immgen_tag   = tag_p[STAGES-1];
  assign o_immgen_err   = err_p[STAGES-1];

endmodule

// File: tb/tb_rv_immgen_pipe.sv
// Bench for rv_immgen_pipe: three configurations share one input stream; directed
// decode vectors, back-pressure, flush, reset and a randomized scoreboard run.
module tb_rv_immgen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, vin, rdy;
  logic [24:0] instr;
  logic [2:0]  ctrl;
  logic [4:0]  tag;

  logic        a_ordy, a_val, a_err;
  logic [31:0] a_res;
  logic [4:0]  a_tag;
  logic        b_ordy, b_val, b_err;
  logic [63:0] b_res;
  logic [4:0]  b_tag;
  logic        c_ordy, c_val, c_err;
  logic [31:0] c_res;
  logic [4:0]  c_tag;

  rv_immgen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_immgen_valid(vin), .o_immgen_ready(a_ordy),
    .i_immgen_instr(instr), .i_immgen_ctrl(ctrl), .i_immgen_tag(tag), .o_immgen_valid(a_val),
    .i_immgen_ready(rdy), .o_immgen_res(a_res), .o_immgen_tag(a_tag), .o_immgen_err(a_err));

  rv_immgen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_immgen_valid(vin), .o_immgen_ready(b_ordy),
    .i_immgen_instr(instr), .i_immgen_ctrl(ctrl), .i_immgen_tag(tag), .o_immgen_valid(b_val),
    .i_immgen_ready(rdy), .o_immgen_res(b_res), .o_immgen_tag(b_tag), .o_immgen_err(b_err));

  rv_immgen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_immgen_valid(vin), .o_immgen_ready(c_ordy),
    .i_immgen_instr(instr), .i_immgen_ctrl(ctrl), .i_immgen_tag(tag), .o_immgen_valid(c_val),
    .i_immgen_ready(rdy), .o_immgen_res(c_res), .o_immgen_tag(c_tag), .o_immgen_err(c_err));

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        err;
  } ent_t;

  localparam int NV = 15;
  vec_t vt [NV];
  ent_t q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] c, input bit x64);
    logic [63:0] r;
    case (c)
      3'd0:    r = {{52{in[31]}}, in[31:20]};
      3'd1:    r = {{52{in[31]}}, in[31:25], in[11:7]};
      3'd2:    r = {{51{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      3'd3:    r = {{43{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      3'd4:    r = {{32{in[31]}}, in[31:12], 12'b0};
      3'd5:    r = x64 ? {58'b0, in[25:20]} : {59'b0, in[24:20]};
      3'd6:    r = {59'b0, in[19:15]};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy = 1'b1; instr = '0; ctrl = '0; tag = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of the randomized run against the 64-bit, 3-stage instance.
  task automatic sb_cycle(input logic v, input logic fl, input logic rd,
                          input logic [31:0] ins, input logic [2:0] c, input logic [4:0] t);
    ent_t e;
    @(negedge clk);
    vin = v; flush = fl; rdy = rd; instr = ins[31:7]; ctrl = c; tag = t;
    #1;
    chk("sb_ready", 64'(b_ordy), 64'((q.size() < 3) || rd));
    if (b_val && rd) begin
      if (q.size() == 0) begin
        chk("sb_spurious_valid", 64'(b_val), 64'd0);
      end else begin
        e = q.pop_front();
        chk("sb_res", b_res, e.res);
        chk("sb_tag", 64'(b_tag), 64'(e.tag));
        chk("sb_err", 64'(b_err), 64'(e.err));
      end
    end
    if (fl) q.delete();
    else if (v && b_ordy) q.push_back('{ref_imm(ins, c, 1'b1), t, c == 3'd7});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[1]  = '{32'h8000006F, 3'd3, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
    vt[2]  = '{32'h80000063, 3'd2, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
    vt[3]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[4]  = '{32'h12345037, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
    vt[5]  = '{32'h80000037, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vt[6]  = '{32'h03F01013, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vt[7]  = '{32'h000FD073, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[8]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vt[9]  = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vt[10] = '{32'h7FFFF06F, 3'd3, 32'h000FFFFE, 64'h00000000000FFFFE, 1'b0};
    vt[11] = '{32'h7E000FE3, 3'd2, 32'h00000FFE, 64'h0000000000000FFE, 1'b0};
    vt[12] = '{32'h41F05013, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[13] = '{32'h00000FA3, 3'd1, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[14] = '{32'hFFF07FFF, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b0};

    rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy = 1'b1; instr = '0; ctrl = '0; tag = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_a_valid", 64'(a_val), 64'd0);
    chk("rst_a_res", 64'(a_res), 64'd0);
    chk("rst_a_tag", 64'(a_tag), 64'd0);
    chk("rst_a_err", 64'(a_err), 64'd0);
    chk("rst_b_valid", 64'(b_val), 64'd0);
    chk("rst_b_res", b_res, 64'd0);
    chk("rst_c_valid", 64'(c_val), 64'd0);

    // Decode table: one entry at a time, checked at each instance's latency.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      vin = 1'b1; rdy = 1'b1; instr = vt[i].instr[31:7]; ctrl = vt[i].ctrl; tag = 5'(i + 3);
      @(posedge clk); #1;
      chk("tbl_a_valid", 64'(a_val), 64'd1);
      chk("tbl_a_res", 64'(a_res), 64'(vt[i].e32));
      chk("tbl_a_err", 64'(a_err), 64'(vt[i].err));
      chk("tbl_a_tag", 64'(a_tag), 64'(i + 3));
      @(negedge clk);
      vin = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("tbl_b_valid", 64'(b_val), 64'd1);
      chk("tbl_b_res", b_res, vt[i].e64);
      chk("tbl_b_err", 64'(b_err), 64'(vt[i].err));
      chk("tbl_b_tag", 64'(b_tag), 64'(i + 3));
    end

    // Back-pressure on the 3-stage instance: fill, hold, release.
    do_reset();
    @(negedge clk);
    rdy = 1'b0; vin = 1'b1; ctrl = 3'd0;
    for (int t = 1; t <= 3; t++) begin
      tag = 5'(t); instr = {12'(t), 13'd0};
      #1;
      chk("bp_ready_fill", 64'(b_ordy), 64'd1);
      @(negedge clk);
    end
    tag = 5'd4; instr = {12'd4, 13'd0};
    for (int h = 0; h < 3; h++) begin
      #1;
      chk("bp_ready_full", 64'(b_ordy), 64'd0);
      chk("bp_hold_valid", 64'(b_val), 64'd1);
      chk("bp_hold_tag", 64'(b_tag), 64'd1);
      chk("bp_hold_res", b_res, 64'd1);
      @(negedge clk);
    end
    rdy = 1'b1;
    #1;
    chk("bp_ready_release", 64'(b_ordy), 64'd1);
    for (int t = 2; t <= 4; t++) begin
      @(posedge clk); #1;
      vin = 1'b0;
      chk("bp_order_valid", 64'(b_val), 64'd1);
      chk("bp_order_tag", 64'(b_tag), 64'(t));
      chk("bp_order_res", b_res, 64'(t));
    end
    @(posedge clk); #1;
    chk("bp_drained", 64'(b_val), 64'd0);

    // Flush with two entries in flight plus a valid input in the flush cycle.
    do_reset();
    @(negedge clk);
    rdy = 1'b0; vin = 1'b1; ctrl = 3'd0; tag = 5'd1; instr = {12'd1, 13'd0};
    @(negedge clk);
    tag = 5'd2; instr = {12'd2, 13'd0};
    @(negedge clk);
    #1;
    chk("fl_c_full", 64'(c_ordy), 64'd0);
    chk("fl_c_valid_before", 64'(c_val), 64'd1);
    flush = 1'b1; tag = 5'd3; instr = {12'd3, 13'd0};
    #1;
    chk("fl_b_ready_in_flush", 64'(b_ordy), 64'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      flush = 1'b0; vin = 1'b0; rdy = 1'b1;
      #1;
      chk("fl_c_no_valid", 64'(c_val), 64'd0);
      chk("fl_b_no_valid", 64'(b_val), 64'd0);
    end

    // Reset asserted mid-stream drops everything and clears the data.
    do_reset();
    @(negedge clk);
    rdy = 1'b0; vin = 1'b1; ctrl = 3'd0; tag = 5'd31; instr = {12'hFFF, 13'd0};
    @(negedge clk);
    tag = 5'd30;
    @(negedge clk);
    tag = 5'd29;
    @(negedge clk);
    #1;
    chk("mr_b_valid_before", 64'(b_val), 64'd1);
    chk("mr_b_tag_before", 64'(b_tag), 64'd31);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; vin = 1'b0;
    #1;
    chk("mr_b_valid", 64'(b_val), 64'd0);
    chk("mr_b_res", b_res, 64'd0);
    chk("mr_b_tag", 64'(b_tag), 64'd0);
    chk("mr_b_err", 64'(b_err), 64'd0);
    chk("mr_c_valid", 64'(c_val), 64'd0);
    chk("mr_c_res", 64'(c_res), 64'd0);
    chk("mr_c_tag", 64'(c_tag), 64'd0);
    chk("mr_a_res", 64'(a_res), 64'd0);

    // Randomized stall/flush run against the queue reference.
    do_reset();
    q.delete();
    for (int n = 0; n < 400; n++) begin
      sb_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
               $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      sb_cycle(1'b0, 1'b0, 1'b1, 32'd0, 3'd0, 5'd0);
    end
    chk("sb_drain_empty", 64'(q.size()), 64'd0);
    sb_cycle(1'b0, 1'b0, 1'b1, 32'd0, 3'd0, 5'd0);
    chk("sb_final_idle", 64'(b_val), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
